// File: rtl/ps2_rx_if.sv
// ps2_rx_if: raw PS/2 pins into the receiver and the decoded byte stream out of it.
interface ps2_rx_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       ps2_key_en;
    logic [7:0] ps2_key_data;
    logic       frame_err;
    logic       busy;
    modport master(input ps2_clk, ps2_dat, output ps2_key_en, ps2_key_data, frame_err, busy);
    modport slave(output ps2_clk, ps2_dat, input ps2_key_en, ps2_key_data, frame_err, busy);
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver; syncs and de-glitches the pins, decodes
// 11-bit frames and strobes out each valid byte or a frame error.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic       clk,
    input logic       reset_n,
    ps2_rx_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t        state;
    logic [1:0]    clk_s, dat_s;
    logic          filt, filt_d, par, fall, dat, tmo;
    logic [7:0]    f_cnt, shift;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    assign fall = filt_d & ~filt;
    assign dat  = dat_s[1];
    assign tmo  = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    // filtered clock follows the synced pin only after FILTER_LEN differing samples in a row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s  <= 2'b11;
            dat_s  <= 2'b11;
            filt   <= 1'b1;
            filt_d <= 1'b1;
            f_cnt  <= '0;
        end else begin
            clk_s  <= {clk_s[0], bus.ps2_clk};
            dat_s  <= {dat_s[0], bus.ps2_dat};
            filt_d <= filt;
            if (clk_s[1] != filt && f_cnt == 8'(FILTER_LEN - 1)) begin
                filt  <= clk_s[1];
                f_cnt <= '0;
            end else begin
                f_cnt <= (clk_s[1] != filt) ? f_cnt + 8'd1 : '0;
            end
        end
    end
    // a timeout outranks a fall arriving on the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            bus.ps2_key_en   <= 1'b0;
            bus.ps2_key_data <= '0;
            bus.frame_err    <= 1'b0;
            bus.busy         <= 1'b0;
            shift            <= '0;
            bit_cnt          <= '0;
            to_cnt           <= '0;
            par              <= 1'b0;
        end else begin
            bus.ps2_key_en <= 1'b0;
            bus.frame_err  <= 1'b0;
            to_cnt         <= (state == IDLE || fall || tmo) ? '0 : to_cnt + 1'b1;
            if (tmo) begin
                state         <= IDLE;
                bus.busy      <= 1'b0;
                bus.frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    IDLE: if (!dat) begin
                        state    <= DATA;
                        bit_cnt  <= '0;
                        bus.busy <= 1'b1;
                    end
                    DATA: begin
                        shift   <= {dat, shift[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat;
                        state <= STOP;
                    end
                    STOP: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        if (dat && (^shift ^ par)) begin
                            bus.ps2_key_data <= shift;
                            bus.ps2_key_en   <= 1'b1;
                        end else begin
                            bus.frame_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: random and directed PS/2 frames; a queue of expected bytes/errors
// is drained by a monitor watching the receiver's strobes.
`timescale 1ns/1ps
module tb_ps2_rx;
    localparam int HALF = 20;
    localparam int TMO  = 3000;
    typedef struct packed {logic err; logic [7:0] data;} exp_t;
    logic clk = 1'b0, reset_n = 1'b0;
    int total = 0, bad = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [7:0] last_key;
    ps2_rx_if bus();
    ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            last_key = 8'h00;
        end else if (bus.ps2_key_en || bus.frame_err) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe key_en=%0b err=%0b data=%h", bus.ps2_key_en, bus.frame_err, bus.ps2_key_data);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", {30'd0, bus.ps2_key_en, bus.frame_err}, e.err ? 32'd1 : 32'd2);
                if (!e.err) last_key = e.data;
                chk(e.err ? "held_data" : "key_data", bus.ps2_key_data, last_key);
            end
        end
    end

    task automatic send_bit(input logic b);
        bus.ps2_dat = b;
        repeat (HALF) @(posedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic glitch();
        bus.ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        bus.ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int glitch_at);
        exp_t x;
        x.err  = !(s && ((^d) ^ p));
        x.data = x.err ? 8'h00 : d;
        exp_q.push_back(x);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (i == glitch_at) glitch();
        end
        send_bit(p);
        send_bit(s);
        bus.ps2_dat = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("busy_after_frame", {31'd0, bus.busy}, 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        @(negedge clk);
        chk({nm, "_key_en"}, {31'd0, bus.ps2_key_en}, 0);
        chk({nm, "_key_data"}, {24'd0, bus.ps2_key_data}, 0);
        chk({nm, "_frame_err"}, {31'd0, bus.frame_err}, 0);
        chk({nm, "_busy"}, {31'd0, bus.busy}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic p, s;
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, -1);
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, -1);
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, -1);
        send_frame(8'h1C, ~odd_par(8'h1C), 1'b1, -1);
        send_frame(8'h1C, odd_par(8'h1C), 1'b0, -1);
        glitch();
        @(negedge clk);
        chk("busy_after_idle_glitch", {31'd0, bus.busy}, 0);
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 3);
        // truncated frame: start plus five data bits, then silence
        exp_q.push_back('{err: 1'b1, data: 8'h00});
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1)));
        bus.ps2_dat = 1'b1;
        repeat (TMO / 2) @(posedge clk);
        @(negedge clk);
        chk("busy_before_timeout", {31'd0, bus.busy}, 1);
        chk("timeout_pending", exp_q.size(), 1);
        repeat (TMO) @(posedge clk);
        @(negedge clk);
        chk("timeout_reported", exp_q.size(), 0);
        chk("busy_after_timeout", {31'd0, bus.busy}, 0);
        send_frame(8'hE0, odd_par(8'hE0), 1'b1, -1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(1)));
        reset_n = 1'b0;
        exp_q.delete();
        check_reset_outputs("midframe_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus.ps2_dat = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(8'h29, odd_par(8'h29), 1'b1, -1);
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            p = ($urandom_range(4) == 0) ? ~odd_par(d) : odd_par(d);
            s = ($urandom_range(7) != 0);
            send_frame(d, p, s, ($urandom_range(5) == 0) ? int'($urandom_range(7)) : -1);
        end
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("final_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
